// File: rtl/pm_loader.sv
// Boot-time program-memory writer: assembles a big-endian byte stream into PM words
// and holds the program sequencer in reset until the whole image has been written.
module pm_loader #(
    parameter int unsigned PMA_SIZE = 16,
    parameter int unsigned PMD_SIZE = 32,
    parameter int unsigned CNT_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          host_dt,
    input  logic                host_vld,
    output logic                ldr_rdy,
    output logic                ldr_pm_cslt,
    output logic                ldr_pm_wrb,
    output logic [PMA_SIZE-1:0] ldr_pm_add,
    output logic [PMD_SIZE-1:0] ldr_pm_dt,
    output logic                ldr_ps_rst,
    output logic                ldr_done,
    output logic                ldr_err
);

    localparam int unsigned BPW = PMD_SIZE / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_ADD_HI,
        S_ADD_LO,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [PMA_SIZE-1:0] addr_q, addr_d;
    logic [PMD_SIZE-1:0] word_q, word_d;
    logic [BCW-1:0]      bcnt_q, bcnt_d;

    logic                rdy_q, rdy_d;
    logic                wr_q, wr_d;
    logic [PMA_SIZE-1:0] add_out_q, add_out_d;
    logic [PMD_SIZE-1:0] dt_out_q, dt_out_d;
    logic                psrst_q, psrst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept_c;

    assign accept_c = host_vld && rdy_q;

    // Next-state, datapath and next-output logic; outputs are decoded from the next state
    // so that every output register lines up with the state it describes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;

        case (state_q)
            S_CNT_HI: if (accept_c) begin
                cnt_d   = CNT_SIZE'({cnt_q, host_dt});
                state_d = S_CNT_LO;
            end
            S_CNT_LO: if (accept_c) begin
                cnt_d   = CNT_SIZE'({cnt_q, host_dt});
                state_d = S_ADD_HI;
            end
            S_ADD_HI: if (accept_c) begin
                addr_d  = PMA_SIZE'({addr_q, host_dt});
                state_d = S_ADD_LO;
            end
            S_ADD_LO: if (accept_c) begin
                addr_d  = PMA_SIZE'({addr_q, host_dt});
                state_d = (cnt_q != '0) ? S_DATA : S_DONE;
            end
            S_DATA: if (accept_c) begin
                word_d = PMD_SIZE'({word_q, host_dt});
                if (bcnt_q == BCW'(BPW - 1)) begin
                    bcnt_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    bcnt_d = BCW'(bcnt_q + 1'b1);
                end
            end
            S_WRITE: begin
                addr_d  = PMA_SIZE'(addr_q + 1'b1);
                cnt_d   = CNT_SIZE'(cnt_q - 1'b1);
                bcnt_d  = '0;
                state_d = (cnt_q != CNT_SIZE'(1)) ? S_DATA : S_DONE;
            end
            S_DONE: if (host_vld) begin
                err_d = 1'b1;
            end
            default: state_d = S_CNT_HI;
        endcase

        wr_d      = (state_d == S_WRITE);
        rdy_d     = (state_d != S_WRITE) && (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        psrst_d   = (state_d != S_DONE);
        add_out_d = wr_d ? addr_q : add_out_q;
        dt_out_d  = wr_d ? word_d : dt_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CNT_HI;
            cnt_q     <= '0;
            addr_q    <= '0;
            word_q    <= '0;
            bcnt_q    <= '0;
            rdy_q     <= 1'b0;
            wr_q      <= 1'b0;
            add_out_q <= '0;
            dt_out_q  <= '0;
            psrst_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            word_q    <= word_d;
            bcnt_q    <= bcnt_d;
            rdy_q     <= rdy_d;
            wr_q      <= wr_d;
            add_out_q <= add_out_d;
            dt_out_q  <= dt_out_d;
            psrst_q   <= psrst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ldr_rdy     = rdy_q;
    assign ldr_pm_cslt = wr_q;
    assign ldr_pm_wrb  = wr_q;
    assign ldr_pm_add  = add_out_q;
    assign ldr_pm_dt   = dt_out_q;
    assign ldr_ps_rst  = psrst_q;
    assign ldr_done    = done_q;
    assign ldr_err     = err_q;

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: table of load images driven with random host gaps, checked
// against a stream-level model, plus directed reset-mid-load and byte-after-done sequences.
module tb_pm_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  host_dt;
    logic        host_vld;
    logic        ldr_rdy, ldr_pm_cslt, ldr_pm_wrb, ldr_ps_rst, ldr_done, ldr_err;
    logic [15:0] ldr_pm_add;
    logic [31:0] ldr_pm_dt;

    int n_checks = 0;
    int n_fail   = 0;

    pm_loader dut (
        .clk         (clk),
        .reset       (reset),
        .host_dt     (host_dt),
        .host_vld    (host_vld),
        .ldr_rdy     (ldr_rdy),
        .ldr_pm_cslt (ldr_pm_cslt),
        .ldr_pm_wrb  (ldr_pm_wrb),
        .ldr_pm_add  (ldr_pm_add),
        .ldr_pm_dt   (ldr_pm_dt),
        .ldr_ps_rst  (ldr_ps_rst),
        .ldr_done    (ldr_done),
        .ldr_err     (ldr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        logic [15:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] got_add[$];
    logic [31:0] got_dt[$];
    int          wr_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " rdy"},  64'(ldr_rdy), 64'd0);
        chk({tag, " cslt"}, 64'(ldr_pm_cslt), 64'd0);
        chk({tag, " wrb"},  64'(ldr_pm_wrb), 64'd0);
        chk({tag, " add"},  64'(ldr_pm_add), 64'd0);
        chk({tag, " dt"},   64'(ldr_pm_dt), 64'd0);
        chk({tag, " psrst"}, 64'(ldr_ps_rst), 64'd1);
        chk({tag, " done"}, 64'(ldr_done), 64'd0);
        chk({tag, " err"},  64'(ldr_err), 64'd0);
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        reset    = 1'b1;
        host_vld = 1'b0;
        @(negedge clk);
        if (check) check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        if (check) chk("rdy after reset", 64'(ldr_rdy), 64'd1);
    endtask

    // Drives one image byte-by-byte with random host_vld gaps and checks the
    // resulting PM writes against the image: word i lands at addr+i (mod 2^16).
    task automatic run_load(input int cnt, input logic [15:0] addr,
                            input logic [31:0] w0, input logic [31:0] w1, input int gap);
        logic [31:0] words[$];
        logic [7:0]  stream[$];
        logic [31:0] w;
        logic [15:0] c16;
        int          cyc, done_cyc, last_acc;
        bit          ps_bad, rdy_bad;

        c16 = 16'(cnt);
        for (int i = 0; i < cnt; i++) begin
            w = (i == 0) ? w0 : (i == 1) ? w1 : $urandom();
            words.push_back(w);
        end
        stream.push_back(c16[15:8]);
        stream.push_back(c16[7:0]);
        stream.push_back(addr[15:8]);
        stream.push_back(addr[7:0]);
        foreach (words[i]) begin
            w = words[i];
            for (int b = 3; b >= 0; b--) stream.push_back(w[b*8 +: 8]);
        end

        got_add.delete();
        got_dt.delete();
        wr_cyc.delete();
        cyc = 0; done_cyc = -1; last_acc = -1;
        ps_bad = 1'b0; rdy_bad = 1'b0;

        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (ldr_pm_wrb) begin
                got_add.push_back(ldr_pm_add);
                got_dt.push_back(ldr_pm_dt);
                wr_cyc.push_back(cyc);
                if (ldr_rdy || !ldr_pm_cslt) rdy_bad = 1'b1;
            end
            if (ldr_done) begin
                if (done_cyc < 0) done_cyc = cyc;
            end else if (!ldr_ps_rst) begin
                ps_bad = 1'b1;
            end
            if (done_cyc >= 0 && stream.size() == 0) begin
                host_vld = 1'b0;
                break;
            end
            if (stream.size() > 0 && $urandom_range(99) >= gap) begin
                host_vld = 1'b1;
                host_dt  = stream[0];
                if (ldr_rdy) begin
                    void'(stream.pop_front());
                    last_acc = cyc;
                end
            end else begin
                host_vld = 1'b0;
            end
        end

        chk("load completed in budget", 64'(done_cyc >= 0 && stream.size() == 0), 64'd1);
        chk("write count", 64'(got_add.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < got_add.size(); i++) begin
            chk($sformatf("write%0d add", i), 64'(got_add[i]), 64'(16'(addr + 16'(i))));
            chk($sformatf("write%0d dt", i), 64'(got_dt[i]), 64'(words[i]));
        end
        chk("rdy low and cslt high on writes", 64'(rdy_bad), 64'd0);
        chk("ps_rst high while loading", 64'(ps_bad), 64'd0);
        if (cnt == 0)
            chk("done after last header byte", 64'(done_cyc), 64'(last_acc + 1));
        else if (wr_cyc.size() > 0)
            chk("done after last write", 64'(done_cyc), 64'(wr_cyc[wr_cyc.size()-1] + 1));
        if (gap == 0)
            for (int i = 1; i < wr_cyc.size(); i++)
                chk("write spacing", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd5);

        @(negedge clk);
        chk("done: wrb", 64'(ldr_pm_wrb), 64'd0);
        chk("done: rdy", 64'(ldr_rdy), 64'd0);
        chk("done: ps_rst", 64'(ldr_ps_rst), 64'd0);
        chk("done: flag", 64'(ldr_done), 64'd1);
        chk("done: err", 64'(ldr_err), 64'd0);
    endtask

    initial begin
        logic [7:0] partial[6];
        bit         saw_wr;

        reset    = 1'b1;
        host_vld = 1'b0;
        host_dt  = 8'h00;

        tbl[0] = '{2, 16'h0010, 32'h11223344, 32'hAABBCCDD, 0,  2, 16'h0010, 16'h0011};
        tbl[1] = '{0, 16'h1234, 32'h0,        32'h0,        0,  0, 16'h0000, 16'h0000};
        tbl[2] = '{2, 16'hFFFF, 32'hCAFEF00D, 32'h01020304, 0,  2, 16'hFFFF, 16'h0000};
        tbl[3] = '{3, 16'h0100, $urandom(),   $urandom(),   40, 3, 16'h0100, 16'h0102};
        tbl[4] = '{5, 16'hFFFD, $urandom(),   $urandom(),   30, 5, 16'hFFFD, 16'h0001};
        tbl[5] = '{4, 16'h7FFE, $urandom(),   $urandom(),   60, 4, 16'h7FFE, 16'h0001 + 16'h8000};

        for (int t = 0; t < 6; t++) begin
            do_reset(1'b1);
            run_load(tbl[t].cnt, tbl[t].addr, tbl[t].w0, tbl[t].w1, tbl[t].gap);
            chk($sformatf("vec%0d n", t), 64'(got_add.size()), 64'(tbl[t].exp_n));
            if (tbl[t].exp_n > 0 && got_add.size() > 0) begin
                chk($sformatf("vec%0d first add", t), 64'(got_add[0]), 64'(tbl[t].exp_first));
                chk($sformatf("vec%0d last add", t), 64'(got_add[got_add.size()-1]),
                    64'(tbl[t].exp_last));
            end
        end

        // Reset after two data bytes of a one-word image: the partial word must vanish.
        do_reset(1'b0);
        partial = '{8'h00, 8'h01, 8'h00, 8'h00, 8'hAB, 8'hCD};
        saw_wr  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ldr_pm_wrb) saw_wr = 1'b1;
            host_vld = 1'b1;
            host_dt  = partial[i];
        end
        @(negedge clk);
        if (ldr_pm_wrb) saw_wr = 1'b1;
        chk("partial: no write", 64'(saw_wr), 64'd0);
        chk("partial: still in reset of PS", 64'(ldr_ps_rst), 64'd1);
        reset    = 1'b1;
        host_vld = 1'b0;
        @(negedge clk);
        check_reset_values("mid-load reset");
        reset = 1'b0;
        run_load(1, 16'h0005, 32'hDEADBEEF, 32'h0, 0);

        // Bytes offered after done: flag an error, never write, stay done.
        saw_wr   = 1'b0;
        host_vld = 1'b1;
        host_dt  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ldr_pm_wrb) saw_wr = 1'b1;
        end
        host_vld = 1'b0;
        @(negedge clk);
        chk("after-done: err", 64'(ldr_err), 64'd1);
        chk("after-done: done", 64'(ldr_done), 64'd1);
        chk("after-done: no write", 64'(saw_wr), 64'd0);
        chk("after-done: rdy", 64'(ldr_rdy), 64'd0);
        @(negedge clk);
        chk("err sticky", 64'(ldr_err), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
